// File: rtl/conn_link_pkg.sv
//------------------------------------------------------------------------------
// conn_link_pkg : shared types and helpers for the conn_link connector block
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package conn_link_pkg;

    localparam int PAR_MAXW = 1024;

    typedef enum logic [0:0] {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } tx_state_e;

    function automatic int beats(input int nchan, input int npins);
        return (nchan + npins - 1) / npins;
    endfunction

    // Zero-extended inputs leave the XOR reduction unchanged.
    function automatic logic odd_par(input logic [PAR_MAXW-1:0] d);
        return ~^d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/conn_link_if.sv
//------------------------------------------------------------------------------
// conn_link_if : channel-side word interface of conn_link (TX and RX words)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface conn_link_if #(
    parameter int NCHAN = 90
) ();
    logic [NCHAN-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [NCHAN-1:0] rx_data;
    logic             rx_valid;
    logic             rx_perr;
    logic             rx_frame_err;
    logic             rx_err_clr;

    modport master (
        output tx_data, tx_valid, rx_err_clr,
        input  tx_ready, rx_data, rx_valid, rx_perr, rx_frame_err
    );

    modport slave (
        input  tx_data, tx_valid, rx_err_clr,
        output tx_ready, rx_data, rx_valid, rx_perr, rx_frame_err
    );
endinterface

`default_nettype wire

// File: rtl/conn_link_rx.sv
//------------------------------------------------------------------------------
// conn_link_rx : receive assembler with per-frame parity and framing errors
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module conn_link_rx
    import conn_link_pkg::*;
#(
    parameter int NCHAN = 90,
    parameter int NPINS = 10
) (
    input  wire logic             CLK,
    input  wire logic             RESET,
    input  wire logic [NPINS-1:0] pin_rx_d,
    input  wire logic             pin_rx_frame,
    input  wire logic             pin_rx_par,
    input  wire logic             rx_err_clr,
    output logic      [NCHAN-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rx_perr,
    output logic                  rx_frame_err
);

    localparam int BEATS    = beats(NCHAN, NPINS);
    localparam int SW       = BEATS * NPINS;
    localparam int CW       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam bit ONE_BEAT = (BEATS == 1);

    logic [NPINS-1:0] r_d;
    logic             r_f;
    logic             r_p;
    logic [CW-1:0]    r_cnt;
    logic [SW-1:0]    r_acc;
    logic             r_perr_acc;

    logic          w_active;
    logic          w_done;
    logic          w_beat_perr;
    logic          w_frame_perr;
    logic [SW-1:0] w_asm;

    // Beats enter at the top and walk down, so beat 0 lands at bit 0 after BEATS shifts.
    assign w_asm        = (SW'(r_d) << (SW - NPINS)) | (r_acc >> NPINS);
    assign w_active     = r_f || (r_cnt != '0);
    assign w_done       = r_f ? ONE_BEAT : (r_cnt == CW'(BEATS - 1));
    assign w_beat_perr  = (r_p != odd_par(PAR_MAXW'(r_d)));
    assign w_frame_perr = w_beat_perr | (r_perr_acc & ~r_f);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_d          <= '0;
            r_f          <= 1'b0;
            r_p          <= 1'b1;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_perr_acc   <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_perr      <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            r_d      <= pin_rx_d;
            r_f      <= pin_rx_frame;
            r_p      <= pin_rx_par;
            rx_valid <= 1'b0;

            if (w_active) begin
                r_acc      <= w_asm;
                r_perr_acc <= w_frame_perr;
                if (w_done) begin
                    r_cnt    <= '0;
                    rx_valid <= 1'b1;
                    rx_data  <= w_asm[NCHAN-1:0];
                    rx_perr  <= w_frame_perr;
                end else if (r_f) begin
                    r_cnt <= CW'(1);
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            if (r_f && (r_cnt != '0)) begin
                rx_frame_err <= 1'b1;
            end else if (rx_err_clr) begin
                rx_frame_err <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/conn_link.sv
//------------------------------------------------------------------------------
// conn_link : time-multiplexed board-to-board link, TX serializer plus RX assembler
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module conn_link
    import conn_link_pkg::*;
#(
    parameter int NCHAN = 90,
    parameter int NPINS = 10
) (
    input  wire logic             CLK,
    input  wire logic             RESET,
    conn_link_if.slave            ch,
    output logic      [NPINS-1:0] pin_tx_d,
    output logic                  pin_tx_frame,
    output logic                  pin_tx_par,
    input  wire logic [NPINS-1:0] pin_rx_d,
    input  wire logic             pin_rx_frame,
    input  wire logic             pin_rx_par
);

    localparam int BEATS = beats(NCHAN, NPINS);
    localparam int SW    = BEATS * NPINS;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    tx_state_e        r_state;
    tx_state_e        w_state_nxt;
    logic [BW-1:0]    r_beat;
    logic [BW-1:0]    w_beat_nxt;
    logic [SW-1:0]    r_shift;
    logic [SW-1:0]    w_shift_nxt;
    logic [SW-1:0]    w_pad;
    logic [NPINS-1:0] w_d_nxt;
    logic             w_frame_nxt;
    logic             w_last;
    logic             w_load;

    assign w_pad       = SW'(ch.tx_data);
    assign w_last      = (r_state == TX_SHIFT) && (r_beat == BW'(BEATS - 1));
    assign ch.tx_ready = (r_state == TX_IDLE) || w_last;
    assign w_load      = ch.tx_ready && ch.tx_valid;

    // The pin register holds the beat currently on the wire; r_shift holds the beats still to go.
    always_comb begin
        w_state_nxt = TX_IDLE;
        w_beat_nxt  = '0;
        w_shift_nxt = r_shift;
        w_d_nxt     = '0;
        w_frame_nxt = 1'b0;
        if (w_load) begin
            w_state_nxt = TX_SHIFT;
            w_shift_nxt = w_pad >> NPINS;
            w_d_nxt     = w_pad[NPINS-1:0];
            w_frame_nxt = 1'b1;
        end else if ((r_state == TX_SHIFT) && !w_last) begin
            w_state_nxt = TX_SHIFT;
            w_beat_nxt  = r_beat + 1'b1;
            w_shift_nxt = r_shift >> NPINS;
            w_d_nxt     = r_shift[NPINS-1:0];
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state      <= TX_IDLE;
            r_beat       <= '0;
            r_shift      <= '0;
            pin_tx_d     <= '0;
            pin_tx_frame <= 1'b0;
            pin_tx_par   <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_beat       <= w_beat_nxt;
            r_shift      <= w_shift_nxt;
            pin_tx_d     <= w_d_nxt;
            pin_tx_frame <= w_frame_nxt;
            pin_tx_par   <= odd_par(PAR_MAXW'(w_d_nxt));
        end
    end

    conn_link_rx #(
        .NCHAN (NCHAN),
        .NPINS (NPINS)
    ) u_rx (
        .CLK          (CLK),
        .RESET        (RESET),
        .pin_rx_d     (pin_rx_d),
        .pin_rx_frame (pin_rx_frame),
        .pin_rx_par   (pin_rx_par),
        .rx_err_clr   (ch.rx_err_clr),
        .rx_data      (ch.rx_data),
        .rx_valid     (ch.rx_valid),
        .rx_perr      (ch.rx_perr),
        .rx_frame_err (ch.rx_frame_err)
    );

endmodule

`default_nettype wire

// File: tb/tb_conn_link.sv
//------------------------------------------------------------------------------
// tb_conn_link : directed scoreboard bench for conn_link (90/10 and 7/3 builds)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_conn_link;

    localparam int NA = 90;
    localparam int PA = 10;
    localparam int BA = 9;
    localparam int NB = 7;
    localparam int PB = 3;
    localparam int BB = 3;

    logic CLK = 1'b0;
    logic RESET;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    conn_link_if #(.NCHAN(NA)) ca ();
    conn_link_if #(.NCHAN(NB)) cb ();

    logic [PA-1:0] a_tx_d, a_rx_d, man_d;
    logic          a_tx_f, a_tx_p, a_rx_f, a_rx_p, man_f, man_p, sel_man;
    logic [PB-1:0] b_tx_d;
    logic          b_tx_f, b_tx_p;

    assign a_rx_d = sel_man ? man_d : a_tx_d;
    assign a_rx_f = sel_man ? man_f : a_tx_f;
    assign a_rx_p = sel_man ? man_p : a_tx_p;

    conn_link #(.NCHAN(NA), .NPINS(PA)) u_a (
        .CLK(CLK), .RESET(RESET), .ch(ca.slave),
        .pin_tx_d(a_tx_d), .pin_tx_frame(a_tx_f), .pin_tx_par(a_tx_p),
        .pin_rx_d(a_rx_d), .pin_rx_frame(a_rx_f), .pin_rx_par(a_rx_p)
    );

    conn_link #(.NCHAN(NB), .NPINS(PB)) u_b (
        .CLK(CLK), .RESET(RESET), .ch(cb.slave),
        .pin_tx_d(b_tx_d), .pin_tx_frame(b_tx_f), .pin_tx_par(b_tx_p),
        .pin_rx_d(b_tx_d), .pin_rx_frame(b_tx_f), .pin_rx_par(b_tx_p)
    );

    // Scoreboard entries are {perr, data}.
    logic [NA:0] qa[$];
    logic [NB:0] qb[$];
    logic [NA:0] ea;
    logic [NB:0] eb;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (ca.rx_valid === 1'b1) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_rx_valid", 128'(ca.rx_valid), 128'(0));
            end else begin
                ea = qa.pop_front();
                chk("a_rx_data", 128'(ca.rx_data), 128'(ea[NA-1:0]));
                chk("a_rx_perr", 128'(ca.rx_perr), 128'(ea[NA]));
            end
        end
        if (cb.rx_valid === 1'b1) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_rx_valid", 128'(cb.rx_valid), 128'(0));
            end else begin
                eb = qb.pop_front();
                chk("b_rx_data", 128'(cb.rx_data), 128'(eb[NB-1:0]));
                chk("b_rx_perr", 128'(cb.rx_perr), 128'(eb[NB]));
            end
        end
    end

    task automatic send_a(input logic [NA-1:0] w, input bit expect_it, output int c0);
        int n = 0;
        while (ca.tx_ready !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) chk("a_tx_ready_timeout", 128'(ca.tx_ready), 128'(1));
        ca.tx_data  = w;
        ca.tx_valid = 1'b1;
        if (expect_it) qa.push_back({1'b0, w});
        c0 = cyc;
        @(posedge CLK);
        #1 ca.tx_valid = 1'b0;
    endtask

    task automatic wait_valid_a(input int c0, input string tag);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (ca.rx_valid !== 1'b1 && n < 40);
        if (ca.rx_valid !== 1'b1) chk({tag, "_timeout"}, 128'(ca.rx_valid), 128'(1));
        else chk(tag, 128'(cyc - c0), 128'(BA + 2));
    endtask

    // Drives a frame straight onto A's RX pins; badbeat flips parity, clrbeat pulses rx_err_clr.
    task automatic man_frame(input logic [NA-1:0] w, input int nbeats, input int badbeat,
                             input int clrbeat);
        logic [NA-1:0] t;
        for (int b = 0; b < nbeats; b++) begin
            t             = w >> (b * PA);
            man_d         = t[PA-1:0];
            man_f         = (b == 0);
            man_p         = (~^t[PA-1:0]) ^ (b == badbeat);
            ca.rx_err_clr = (b == clrbeat);
            @(posedge CLK);
            #1;
        end
        man_d         = '0;
        man_f         = 1'b0;
        man_p         = 1'b1;
        ca.rx_err_clr = 1'b0;
    endtask

    initial begin
        logic [NA-1:0] w1, t;
        logic [NA-1:0] ws[4];
        logic [PB-1:0] bexp[BB];
        int c0, n, ready_low;
        int acc_c[4];

        RESET = 1'b1;
        sel_man = 1'b0; man_d = '0; man_f = 1'b0; man_p = 1'b1;
        ca.tx_data = '0; ca.tx_valid = 1'b0; ca.rx_err_clr = 1'b0;
        cb.tx_data = '0; cb.tx_valid = 1'b0; cb.rx_err_clr = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_tx_ready", 128'(ca.tx_ready), 128'(1));
        chk("rst_pin_d", 128'(a_tx_d), 128'(0));
        chk("rst_pin_frame", 128'(a_tx_f), 128'(0));
        chk("rst_pin_par", 128'(a_tx_p), 128'(1));
        chk("rst_rx_data", 128'(ca.rx_data), 128'(0));
        chk("rst_rx_valid", 128'(ca.rx_valid), 128'(0));
        chk("rst_rx_perr", 128'(ca.rx_perr), 128'(0));
        chk("rst_rx_frame_err", 128'(ca.rx_frame_err), 128'(0));
        chk("rst_b_pin_par", 128'(b_tx_p), 128'(1));
        RESET = 1'b0;
        repeat (2) @(negedge CLK);

        // Single word, pin-level view and loopback latency.
        w1 = {45{2'b10}};
        send_a(w1, 1'b1, c0);
        for (int b = 0; b < BA; b++) begin
            @(negedge CLK);
            t = w1 >> (b * PA);
            chk($sformatf("a_pin_d_b%0d", b), 128'(a_tx_d), 128'(t[PA-1:0]));
            chk($sformatf("a_pin_frame_b%0d", b), 128'(a_tx_f), 128'(b == 0));
            chk($sformatf("a_pin_par_b%0d", b), 128'(a_tx_p), 128'(~^t[PA-1:0]));
            chk($sformatf("a_tx_ready_b%0d", b), 128'(ca.tx_ready), 128'(b == BA - 1));
        end
        @(negedge CLK);
        chk("a_idle_d", 128'(a_tx_d), 128'(0));
        chk("a_idle_frame", 128'(a_tx_f), 128'(0));
        chk("a_idle_par", 128'(a_tx_p), 128'(1));
        wait_valid_a(c0, "a_latency");
        repeat (3) @(negedge CLK);

        // Back-to-back stream with tx_valid held.
        for (int i = 0; i < 4; i++) ws[i] = NA'({$urandom, $urandom, $urandom});
        ready_low = 0;
        for (int i = 0; i < 4; i++) begin
            ca.tx_data  = ws[i];
            ca.tx_valid = 1'b1;
            qa.push_back({1'b0, ws[i]});
            n = 0;
            while (ca.tx_ready !== 1'b1 && n < 50) begin
                ready_low++;
                @(negedge CLK);
                n++;
            end
            acc_c[i] = cyc;
            @(posedge CLK);
            #1;
            chk($sformatf("stream_frame_w%0d", i), 128'(a_tx_f), 128'(1));
            if (i == 3) ca.tx_valid = 1'b0;
            @(negedge CLK);
        end
        for (int i = 1; i < 4; i++)
            chk($sformatf("stream_gap_w%0d", i), 128'(acc_c[i] - acc_c[i-1]), 128'(BA));
        chk("stream_ready_low", 128'(ready_low), 128'(3 * (BA - 1)));
        repeat (16) @(negedge CLK);
        chk("stream_drained", 128'(qa.size()), 128'(0));

        // Parity error on beat 4, then a clean frame.
        sel_man = 1'b1;
        ws[0] = NA'({$urandom, $urandom, $urandom});
        ws[1] = NA'({$urandom, $urandom, $urandom});
        qa.push_back({1'b1, ws[0]});
        man_frame(ws[0], BA, 4, -1);
        qa.push_back({1'b0, ws[1]});
        man_frame(ws[1], BA, -1, -1);
        repeat (4) @(negedge CLK);
        chk("perr_drained", 128'(qa.size()), 128'(0));
        chk("perr_no_frame_err", 128'(ca.rx_frame_err), 128'(0));

        // Frame strobe at beat 5 restarts assembly.
        ws[2] = NA'({$urandom, $urandom, $urandom});
        ws[3] = NA'({$urandom, $urandom, $urandom});
        man_frame(ws[2], 5, -1, -1);
        qa.push_back({1'b0, ws[3]});
        man_frame(ws[3], BA, -1, -1);
        repeat (4) @(negedge CLK);
        chk("ferr_set", 128'(ca.rx_frame_err), 128'(1));
        chk("ferr_drained", 128'(qa.size()), 128'(0));
        ca.rx_err_clr = 1'b1;
        @(posedge CLK);
        #1 ca.rx_err_clr = 1'b0;
        @(negedge CLK);
        chk("ferr_cleared", 128'(ca.rx_frame_err), 128'(0));

        // Clear coincides with a new framing error: the set must win.
        man_frame(ws[2], 3, -1, -1);
        qa.push_back({1'b0, ws[2]});
        man_frame(ws[2], BA, -1, 1);
        repeat (4) @(negedge CLK);
        chk("ferr_set_wins", 128'(ca.rx_frame_err), 128'(1));
        chk("ferr2_drained", 128'(qa.size()), 128'(0));
        ca.rx_err_clr = 1'b1;
        @(posedge CLK);
        #1 ca.rx_err_clr = 1'b0;
        sel_man = 1'b0;
        @(negedge CLK);
        chk("ferr2_cleared", 128'(ca.rx_frame_err), 128'(0));

        // 7-bit word over 3 pins: last beat carries one data bit and two pad zeros.
        bexp[0] = 3'b101;
        bexp[1] = 3'b010;
        bexp[2] = 3'b001;
        chk("b_tx_ready_idle", 128'(cb.tx_ready), 128'(1));
        cb.tx_data  = 7'h55;
        cb.tx_valid = 1'b1;
        qb.push_back({1'b0, 7'h55});
        c0 = cyc;
        @(posedge CLK);
        #1 cb.tx_valid = 1'b0;
        for (int b = 0; b < BB; b++) begin
            @(negedge CLK);
            chk($sformatf("b_pin_d_b%0d", b), 128'(b_tx_d), 128'(bexp[b]));
            chk($sformatf("b_pin_frame_b%0d", b), 128'(b_tx_f), 128'(b == 0));
            chk($sformatf("b_pin_par_b%0d", b), 128'(b_tx_p), 128'(~^bexp[b]));
        end
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (cb.rx_valid !== 1'b1 && n < 20);
        if (cb.rx_valid !== 1'b1) chk("b_latency_timeout", 128'(cb.rx_valid), 128'(1));
        else chk("b_latency", 128'(cyc - c0), 128'(BB + 2));
        repeat (3) @(negedge CLK);

        // Reset asserted while beat 3 is on the pins.
        w1 = NA'({$urandom, $urandom, $urandom});
        send_a(w1, 1'b0, c0);
        repeat (4) @(negedge CLK);
        t = w1 >> (3 * PA);
        chk("midrst_beat3", 128'(a_tx_d), 128'(t[PA-1:0]));
        RESET = 1'b1;
        #1;
        chk("midrst_tx_ready", 128'(ca.tx_ready), 128'(1));
        chk("midrst_pin_d", 128'(a_tx_d), 128'(0));
        chk("midrst_pin_frame", 128'(a_tx_f), 128'(0));
        chk("midrst_pin_par", 128'(a_tx_p), 128'(1));
        chk("midrst_rx_data", 128'(ca.rx_data), 128'(0));
        chk("midrst_rx_valid", 128'(ca.rx_valid), 128'(0));
        chk("midrst_rx_perr", 128'(ca.rx_perr), 128'(0));
        chk("midrst_rx_frame_err", 128'(ca.rx_frame_err), 128'(0));
        @(negedge CLK);
        RESET = 1'b0;
        repeat (15) @(negedge CLK);
        w1 = NA'({$urandom, $urandom, $urandom});
        send_a(w1, 1'b1, c0);
        wait_valid_a(c0, "a_latency_after_reset");
        repeat (5) @(negedge CLK);
        chk("final_qa_empty", 128'(qa.size()), 128'(0));
        chk("final_qb_empty", 128'(qb.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/conn_link.md
# conn_link

Parametrised, registered successor to the passive backplane connector models. It carries an NCHAN-bit parallel channel word across NPINS physical data pins by time-multiplexing it over several beats, with a frame strobe and a per-beat odd-parity pin. Transmitter and receiver share one clock. The block sits on either side of a board-to-board connector: the TX pins of one instance loop to the RX pins of its peer.

## Interface
Parameters:
- NCHAN, 90: channel word width in bits, ≥1.
- NPINS, 10: data pins per beat, 1..NCHAN.
- BEATS, derived, ceil(NCHAN/NPINS): beats per frame.

Ports:
- CLK  in  1  single clock; all logic is rising-edge.
- RESET  in  1  asynchronous, active-high reset.
- tx_data  in  NCHAN  word to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  transmitter accepts a word this cycle.
- pin_tx_d  out  NPINS  registered data pins.
- pin_tx_frame  out  1  high on beat 0 of each frame.
- pin_tx_par  out  1  odd parity over pin_tx_d.
- pin_rx_d  in  NPINS  received data pins.
- pin_rx_frame  in  1  received frame strobe.
- pin_rx_par  in  1  received parity.
- rx_data  out  NCHAN  assembled word; held until the next rx_valid.
- rx_valid  out  1  one-cycle pulse when a complete word is delivered.
- rx_perr  out  1  qualifies rx_valid: at least one beat of this frame had a parity error.
- rx_frame_err  out  1  sticky: frame strobe arrived while a frame was only partly assembled.
- rx_err_clr  in  1  clears rx_frame_err.

## Operation
- TX FSM, states IDLE and SHIFT.
  - IDLE: tx_ready=1. When tx_valid is high, load the word into the shift register and go to SHIFT with beat counter = 0.
  - SHIFT: each cycle drive bits [b*NPINS +: NPINS] of the word on pin_tx_d. Bits above NCHAN-1 on the last beat are 0.
  - pin_tx_frame=1 when b=0. pin_tx_par = ~^pin_tx_d (odd parity).
  - On the last beat, tx_ready=1. If tx_valid is also high, the next word loads and its beat 0 follows with no gap. Otherwise return to IDLE.
- While IDLE, the pins carry d=0, frame=0 and par=1 (valid odd parity on an idle bus).
- RX side:
  - Ignores beats until pin_rx_frame is seen.
  - Frame high loads beat 0 and sets the beat counter to 1. Subsequent beats fill in order. Beats are inputs registered once.
  - Parity is checked on every accepted beat, and any mismatch is OR-accumulated per frame.
  - After BEATS beats, pulse rx_valid, update rx_data and present rx_perr. The counter then waits for the next frame strobe.
  - Frame high while 0 < counter < BEATS: discard the partial word, set rx_frame_err, and restart at beat 0. No rx_valid is issued for the discarded word.
  - Frame high on the cycle immediately after the last beat is a normal back-to-back frame.
  - rx_err_clr clears rx_frame_err. If a set event and a clear land in the same cycle, set wins.
  - Pad bits in the last beat are dropped and are not checked beyond parity.

## Timing
- Reset values: tx_ready=1, pin_tx_d=0, pin_tx_frame=0, pin_tx_par=1, rx_data=0, rx_valid=0, rx_perr=0, rx_frame_err=0. Both FSMs return to idle.
- Reset asserted mid-frame aborts the frame immediately. There is no partial rx_valid.
- Word accepted at cycle 0: beat b appears on the pins at cycle 1+b.
- Direct loopback: the RX input register captures beat b at cycle 2+b. rx_valid is high at cycle BEATS+2, giving TX-accept-to-rx_valid latency of BEATS+2.
- Throughput: one word every BEATS cycles with tx_valid held high.
- BEATS=1 is legal. tx_ready is then constantly 1 and every beat carries frame=1.

## Structure
- Package conn_link_pkg holds:
  - the function beats(nchan, npins), returning the ceiling division;
  - the TX state encoding (IDLE, SHIFT);
  - the odd-parity function.
- Sub-module conn_link_rx contains the receive assembler and error logic. TX stays in the top level.

## Test plan
- NCHAN=90, NPINS=10, loopback, one word 0x2AA…A: pins show 9 beats with frame on beat 0 only; rx_valid at cycle 11; rx_data matches; rx_perr=0.
- tx_valid held high, 4 words: frames are gapless (frame every 9 cycles), 4 rx_valid pulses in order, tx_ready low for 8 of every 9 cycles.
- Force pin_rx_par inverted on beat 4: rx_valid with rx_perr=1. The next clean frame gives rx_perr=0.
- Inject frame=1 at beat 5 of a frame: rx_frame_err=1, no rx_valid for the partial word, and the new frame is assembled correctly. rx_err_clr then clears the flag.
- NCHAN=7, NPINS=3 (BEATS=3): last-beat upper 2 pins are 0 with parity over the pad; word 0x55 round-trips.
- Assert RESET at beat 3: all outputs take reset values on the next sample. A fresh word afterwards round-trips with latency BEATS+2.
